// File: rtl/mochila_safe_ctrl.sv
// mochila_safe_ctrl: CSR slave plus run sequencer for the safe CPU wrapper.
// Holds mode/config/master-core/boot-address, pulses start, tracks per-hart
// end-of-software, applies an optional cycle watchdog and raises a maskable irq.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | configuration writable, waiting for CTRL.START
// S_START | one-cycle start pulse to the wrapper, clear end_seen/counter
// S_RUN   | collecting end_sw flags, counting cycles against TIMEOUT
// S_DONE  | one cycle after completion or timeout, then back to idle
module mochila_safe_ctrl #(
    parameter int unsigned NHARTS    = 3,
    parameter int unsigned MC_W      = (NHARTS > 1) ? $clog2(NHARTS) : 1,
    parameter logic [31:0] BOOT_RST  = 32'h0,
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 csr_reg_req_i,
    input  logic                 csr_reg_we_i,
    input  logic [3:0]           csr_reg_be_i,
    input  logic [31:0]          csr_reg_addr_i,
    input  logic [31:0]          csr_reg_wdata_i,
    output logic                 csr_reg_gnt_o,
    output logic                 csr_reg_rvalid_o,
    output logic [31:0]          csr_reg_rdata_o,
    input  logic [NHARTS-1:0]    end_sw_i,
    input  logic [NHARTS-1:0]    debug_mode_i,
    input  logic [NHARTS-1:0]    sleep_i,
    output logic                 start_o,
    output logic [MC_W-1:0]      master_core_o,
    output logic                 safe_mode_o,
    output logic [1:0]           safe_configuration_o,
    output logic                 critical_section_o,
    output logic [31:0]          boot_addr_o,
    output logic                 interrupt_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q;
    logic [TIMEOUT_W-1:0]  cnt_q;
    logic [TIMEOUT_W-1:0]  cnt_inc;
    logic [TIMEOUT_W-1:0]  timeout_q;
    logic [NHARTS-1:0]     end_seen_q;
    logic [NHARTS-1:0]     end_seen_nxt;
    logic [NHARTS-1:0]     end_mask_q;
    logic                  irq_en_q;
    logic                  irq_done_q;
    logic                  irq_to_q;

    logic [2:0]  sel;
    logic        wr;
    logic        cfg_wr;
    logic        start_req;
    logic        clr_done;
    logic        clr_to;
    logic        complete;
    logic [31:0] ctrl_wd;
    logic [31:0] mc_wd;
    logic [31:0] ba_wd;
    logic [31:0] em_wd;
    logic [31:0] to_wd;
    logic [31:0] rd_mux;
    logic        unused_bits;

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [7:0] pad8(input logic [NHARTS-1:0] v);
        logic [7:0] r;
        r = '0;
        r[NHARTS-1:0] = v;
        return r;
    endfunction

    assign sel       = csr_reg_addr_i[4:2];
    assign wr        = csr_reg_req_i && csr_reg_we_i;
    // Configuration is frozen while a run is in progress.
    assign cfg_wr    = wr && (state_q == S_IDLE);
    assign start_req = cfg_wr && (sel == 3'd0) && csr_reg_be_i[0] && csr_reg_wdata_i[0];
    assign clr_done  = wr && (sel == 3'd6) && csr_reg_be_i[0] && csr_reg_wdata_i[0];
    assign clr_to    = wr && (sel == 3'd6) && csr_reg_be_i[0] && csr_reg_wdata_i[1];

    assign ctrl_wd = be_merge({26'b0, irq_en_q, critical_section_o, safe_configuration_o,
                               safe_mode_o, 1'b0}, csr_reg_wdata_i, csr_reg_be_i);
    assign mc_wd   = be_merge(32'(master_core_o), csr_reg_wdata_i, csr_reg_be_i);
    assign ba_wd   = be_merge(boot_addr_o, csr_reg_wdata_i, csr_reg_be_i);
    assign em_wd   = be_merge(32'(end_mask_q), csr_reg_wdata_i, csr_reg_be_i);
    assign to_wd   = be_merge(32'(timeout_q), csr_reg_wdata_i, csr_reg_be_i);

    assign cnt_inc      = cnt_q + TIMEOUT_W'(1);
    assign end_seen_nxt = end_seen_q | end_sw_i;
    assign complete     = (end_seen_nxt & end_mask_q) == end_mask_q;

    assign csr_reg_gnt_o = csr_reg_req_i;
    assign interrupt_o   = irq_en_q && (irq_done_q || irq_to_q);

    assign unused_bits = ^{csr_reg_addr_i[31:5], csr_reg_addr_i[1:0], ctrl_wd[31:6],
                           ctrl_wd[0], em_wd[31:NHARTS], to_wd[31:TIMEOUT_W]};

    // Run sequencer: start pulse, end-of-software collection, watchdog and irq flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            start_o    <= 1'b0;
            cnt_q      <= '0;
            end_seen_q <= '0;
            irq_done_q <= 1'b0;
            irq_to_q   <= 1'b0;
        end else begin
            start_o <= 1'b0;
            if (clr_done) irq_done_q <= 1'b0;
            if (clr_to)   irq_to_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_req) begin
                        state_q <= S_START;
                        start_o <= 1'b1;
                    end
                end
                S_START: begin
                    end_seen_q <= '0;
                    cnt_q      <= '0;
                    state_q    <= S_RUN;
                end
                S_RUN: begin
                    end_seen_q <= end_seen_nxt;
                    cnt_q      <= cnt_inc;
                    // Completion takes priority over a simultaneous watchdog expiry.
                    if (complete) begin
                        state_q    <= S_DONE;
                        irq_done_q <= 1'b1;
                    end else if ((timeout_q != '0) && (cnt_inc == timeout_q)) begin
                        state_q  <= S_DONE;
                        irq_to_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Configuration registers, writable only while idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            safe_mode_o          <= 1'b0;
            safe_configuration_o <= 2'b0;
            critical_section_o   <= 1'b0;
            irq_en_q             <= 1'b0;
            master_core_o        <= '0;
            boot_addr_o          <= BOOT_RST;
            end_mask_q           <= '1;
            timeout_q            <= '0;
        end else if (cfg_wr) begin
            case (sel)
                3'd0: begin
                    safe_mode_o          <= ctrl_wd[1];
                    safe_configuration_o <= ctrl_wd[3:2];
                    critical_section_o   <= ctrl_wd[4];
                    irq_en_q             <= ctrl_wd[5];
                end
                3'd1: if (mc_wd < 32'(NHARTS)) master_core_o <= mc_wd[MC_W-1:0];
                3'd2: boot_addr_o <= ba_wd;
                3'd4: end_mask_q  <= em_wd[NHARTS-1:0];
                3'd5: timeout_q   <= to_wd[TIMEOUT_W-1:0];
                default: ;
            endcase
        end
    end

    // Read data selection.
    always_comb begin
        rd_mux = '0;
        case (sel)
            3'd0: rd_mux = {26'b0, irq_en_q, critical_section_o, safe_configuration_o,
                            safe_mode_o, 1'b0};
            3'd1: rd_mux = 32'(master_core_o);
            3'd2: rd_mux = boot_addr_o;
            3'd3: rd_mux = {pad8(end_seen_q), pad8(sleep_i), pad8(debug_mode_i), 5'b0,
                            (state_q != S_IDLE), state_q};
            3'd4: rd_mux = 32'(end_mask_q);
            3'd5: rd_mux = 32'(timeout_q);
            3'd6: rd_mux = {30'b0, irq_to_q, irq_done_q};
            default: rd_mux = '0;
        endcase
    end

    // OBI response: one-cycle rvalid for every grant, rdata only on reads.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            csr_reg_rvalid_o <= 1'b0;
            csr_reg_rdata_o  <= '0;
        end else begin
            csr_reg_rvalid_o <= csr_reg_req_i;
            csr_reg_rdata_o  <= (csr_reg_req_i && !csr_reg_we_i) ? rd_mux : 32'h0;
        end
    end

endmodule

// File: tb/tb_mochila_safe_ctrl.sv
module tb_mochila_safe_ctrl;

    localparam int NH = 3;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic [NH-1:0] end_sw = '0;
    logic [NH-1:0] dbg = '0;
    logic [NH-1:0] slp = '0;
    logic        start_o;
    logic [1:0]  master_core;
    logic        safe_mode;
    logic [1:0]  safe_cfg;
    logic        crit;
    logic [31:0] boot_addr;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    mochila_safe_ctrl #(.NHARTS(NH), .BOOT_RST(32'h0), .TIMEOUT_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .csr_reg_req_i(req), .csr_reg_we_i(we), .csr_reg_be_i(be),
        .csr_reg_addr_i(addr), .csr_reg_wdata_i(wdata),
        .csr_reg_gnt_o(gnt), .csr_reg_rvalid_o(rvalid), .csr_reg_rdata_o(rdata),
        .end_sw_i(end_sw), .debug_mode_i(dbg), .sleep_i(slp),
        .start_o(start_o), .master_core_o(master_core), .safe_mode_o(safe_mode),
        .safe_configuration_o(safe_cfg), .critical_section_o(crit),
        .boot_addr_o(boot_addr), .interrupt_o(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [2:0]  dbg;
        logic [2:0]  slp;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic [2:0] dm, input logic [2:0] sl,
                       input logic [31:0] e);
        vec_t v;
        v.we = w; v.addr = a; v.wdata = d; v.be = b; v.dbg = dm; v.slp = sl; v.exp = e;
        vecs.push_back(v);
    endtask

    // One transfer: grant cycle, then response cycle; returns in the response cycle.
    task automatic xfer(input logic a_we, input logic [31:0] a_addr, input logic [31:0] a_wd,
                        input logic [3:0] a_be, output logic [31:0] rd);
        @(negedge clk);
        req = 1'b1; we = a_we; addr = a_addr; wdata = a_wd; be = a_be;
        #1;
        chk("hs_grant", {30'b0, gnt, rvalid}, 32'h2);
        @(negedge clk);
        req = 1'b0; we = 1'b0; be = 4'h0;
        chk("hs_rvalid", {31'b0, rvalid}, 32'h1);
        rd = rdata;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        xfer(1'b1, a, d, 4'hF, rd);
        chk("wr_rdata_zero", rd, 32'h0);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] e);
        logic [31:0] rd;
        xfer(1'b0, a, 32'h0, 4'hF, rd);
        chk(name, rd, e);
    endtask

    initial begin
        logic [31:0] rd;
        logic any;
        int   starts;
        int   waited;

        // reset-state reads, register access, byte enables, master-core guard
        add(0, 32'h00, 0, 4'hF, 0, 0, 32'h0);
        add(0, 32'h04, 0, 4'hF, 0, 0, 32'h0);
        add(0, 32'h08, 0, 4'hF, 0, 0, 32'h0);
        add(0, 32'h0C, 0, 4'hF, 0, 0, 32'h0);
        add(0, 32'h10, 0, 4'hF, 0, 0, 32'h7);
        add(0, 32'h14, 0, 4'hF, 0, 0, 32'h0);
        add(0, 32'h18, 0, 4'hF, 0, 0, 32'h0);
        add(0, 32'h1C, 0, 4'hF, 0, 0, 32'h0);
        add(0, 32'h0C, 0, 4'hF, 3'b101, 3'b010, 32'h0002_0500);
        add(1, 32'h04, 32'h2, 4'hF, 0, 0, 32'h0);
        add(0, 32'h04, 0, 4'hF, 0, 0, 32'h2);
        add(1, 32'h04, 32'h3, 4'hF, 0, 0, 32'h0);
        add(0, 32'h04, 0, 4'hF, 0, 0, 32'h2);
        add(1, 32'h14, 32'h1234_ABCD, 4'h1, 0, 0, 32'h0);
        add(0, 32'h14, 0, 4'hF, 0, 0, 32'h0000_00CD);
        add(1, 32'h08, 32'h1000_0080, 4'hF, 0, 0, 32'h0);
        add(0, 32'h08, 0, 4'hF, 0, 0, 32'h1000_0080);
        add(1, 32'h1C, 32'hFFFF_FFFF, 4'hF, 0, 0, 32'h0);
        add(0, 32'h1C, 0, 4'hF, 0, 0, 32'h0);
        add(1, 32'h10, 32'h5, 4'h0, 0, 0, 32'h0);
        add(0, 32'h10, 0, 4'hF, 0, 0, 32'h7);
        add(1, 32'h00, 32'h1E, 4'h1, 0, 0, 32'h0);
        add(0, 32'h00, 0, 4'hF, 0, 0, 32'h1E);
        add(1, 32'h14, 32'h0, 4'hF, 0, 0, 32'h0);
        add(0, 32'h14, 0, 4'hF, 0, 0, 32'h0);
        add(1, 32'h00, 32'h0, 4'hF, 0, 0, 32'h0);
        add(0, 32'h00, 0, 4'hF, 0, 0, 32'h0);

        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", {22'b0, start_o, safe_mode, safe_cfg, crit, irq, master_core,
                              rvalid, gnt}, 32'h0);
        chk("reset_boot_addr", boot_addr, 32'h0);
        rst_ni = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            dbg = vecs[i].dbg;
            slp = vecs[i].slp;
            xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
        end
        dbg = '0; slp = '0;
        chk("master_core_out", 32'(master_core), 32'h2);
        chk("boot_addr_out", boot_addr, 32'h1000_0080);

        // completion via staggered end_sw pulses
        wr(32'h00, 32'h23);
        chk("start_pulse_hi", 32'(start_o), 32'h1);
        chk("safe_mode_out", 32'(safe_mode), 32'h1);
        any = 1'b0;
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            end_sw = (k == 2) ? 3'b001 : (k == 4) ? 3'b010 : (k == 6) ? 3'b100 : 3'b000;
            if (k == 2) chk("start_pulse_lo", 32'(start_o), 32'h0);
            any = any | irq;
        end
        chk("done_irq_early", 32'(any), 32'h0);
        @(negedge clk);
        end_sw = '0;
        chk("done_irq", 32'(irq), 32'h1);
        rd_chk("done_irq_status", 32'h18, 32'h1);
        wr(32'h18, 32'h1);
        chk("done_irq_cleared", 32'(irq), 32'h0);
        rd_chk("irq_status_clr", 32'h18, 32'h0);

        // watchdog expiry
        wr(32'h14, 32'd5);
        wr(32'h10, 32'h4);
        wr(32'h00, 32'h23);
        any = 1'b0;
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            any = any | irq;
        end
        chk("to_irq_early", 32'(any), 32'h0);
        @(negedge clk);
        chk("to_irq", 32'(irq), 32'h1);
        rd_chk("to_irq_status", 32'h18, 32'h2);
        rd_chk("to_status", 32'h0C, 32'h0);
        wr(32'h18, 32'h2);

        // completion on the same cycle the watchdog expires
        wr(32'h00, 32'h23);
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            end_sw = (k == 6) ? 3'b100 : 3'b000;
        end
        @(negedge clk);
        end_sw = '0;
        chk("tie_irq", 32'(irq), 32'h1);
        rd_chk("tie_irq_status", 32'h18, 32'h1);
        wr(32'h18, 32'h3);

        // writes during RUN are ignored
        wr(32'h14, 32'd20);
        wr(32'h10, 32'h7);
        wr(32'h00, 32'h23);
        wr(32'h08, 32'hDEAD_BEEF);
        wr(32'h00, 32'h01);
        chk("run_boot_kept", boot_addr, 32'h1000_0080);
        chk("run_ctrl_kept", 32'(safe_mode), 32'h1);
        starts = 0; waited = 0;
        while (irq !== 1'b1 && waited < 40) begin
            @(negedge clk);
            if (start_o) starts++;
            waited++;
        end
        chk("run_to_reached", 32'(irq), 32'h1);
        chk("run_no_restart", 32'(starts), 32'h0);
        repeat (3) @(negedge clk);
        chk("run_no_restart_late", 32'(start_o), 32'h0);
        rd_chk("run_irq_status", 32'h18, 32'h2);
        rd_chk("run_boot_read", 32'h08, 32'h1000_0080);
        wr(32'h18, 32'h3);

        // asynchronous reset in the middle of a run
        wr(32'h14, 32'd9);
        wr(32'h00, 32'h3F);
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        chk("rst_outputs", {22'b0, start_o, safe_mode, safe_cfg, crit, irq, master_core,
                            rvalid, gnt}, 32'h0);
        chk("rst_boot_addr", boot_addr, 32'h0);
        @(negedge clk);
        rst_ni = 1'b1;
        any = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            any = any | start_o;
        end
        chk("rst_no_start", 32'(any), 32'h0);
        rd_chk("rst_status", 32'h0C, 32'h0);
        rd_chk("rst_end_mask", 32'h10, 32'h7);
        rd_chk("rst_timeout", 32'h14, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
